// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath width, default reset/bubble values,
// fetch FSM encoding and small address helpers.
package pipeline_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_FETCH    = 2'd0,
    S_BUFFERED = 2'd1,
    S_DISCARD  = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pipe_reg_ifid.sv
// IF/ID pipeline register: load a captured word, insert a bubble, or hold.
// The caller never asserts load and bubble together.
module pipe_reg_ifid
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            i_load,
  input  logic            i_bubble,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc4,
  output logic            o_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc4
);

  logic            r_valid;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc4;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc4   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
    end else if (i_bubble) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc4   <= '0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, request/ack handshake to instruction memory,
// one-entry skid buffer for words that arrive during stall/flush, and
// redirect handling that drops responses to abandoned requests.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            ifid_valid_o,
  output logic [XLEN-1:0] ifid_instr_o,
  output logic [XLEN-1:0] ifid_pc4_o
);

  fetch_state_e    r_state, w_state_d;
  logic [XLEN-1:0] r_pc, w_pc_d;
  logic [XLEN-1:0] r_tgt, w_tgt_d;
  logic [XLEN-1:0] r_skid_instr, r_skid_pc4;

  logic            w_skid_we;
  logic            w_cap;
  logic            w_bubble;
  logic [XLEN-1:0] w_cap_instr, w_cap_pc4;
  logic [XLEN-1:0] w_pc4, w_redir;

  assign w_pc4   = r_pc + 32'd4;
  assign w_redir = word_align(redirect_pc_i);

  // Request is gated by reset so the bus goes idle immediately on assertion.
  assign imem_req_o  = !RST && (r_state != S_BUFFERED);
  assign imem_addr_o = word_align(r_pc);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_FETCH;
    else     r_state <= w_state_d;
  end

  always_comb begin
    w_state_d   = r_state;
    w_pc_d      = r_pc;
    w_tgt_d     = r_tgt;
    w_skid_we   = 1'b0;
    w_cap       = 1'b0;
    w_cap_instr = imem_rdata_i;
    w_cap_pc4   = w_pc4;
    case (r_state)
      S_FETCH: begin
        if (redirect_i) begin
          if (imem_ack_i) begin
            w_pc_d = w_redir;
          end else begin
            w_tgt_d   = w_redir;
            w_state_d = S_DISCARD;
          end
        end else if (imem_ack_i) begin
          w_pc_d = w_pc4;
          if (stall_i || flush_i) begin
            w_skid_we = 1'b1;
            w_state_d = S_BUFFERED;
          end else begin
            w_cap = 1'b1;
          end
        end
      end
      S_BUFFERED: begin
        if (redirect_i) begin
          w_pc_d    = w_redir;
          w_state_d = S_FETCH;
        end else if (!stall_i && !flush_i) begin
          w_cap       = 1'b1;
          w_cap_instr = r_skid_instr;
          w_cap_pc4   = r_skid_pc4;
          w_state_d   = S_FETCH;
        end
      end
      S_DISCARD: begin
        // A redirect arriving with the stale ack is the newest target.
        if (imem_ack_i) begin
          w_pc_d    = redirect_i ? w_redir : r_tgt;
          w_state_d = S_FETCH;
        end else if (redirect_i) begin
          w_tgt_d = w_redir;
        end
      end
      default: w_state_d = S_FETCH;
    endcase
  end

  assign w_bubble = !w_cap && (flush_i || redirect_i || !stall_i);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc         <= RESET_PC;
      r_tgt        <= '0;
      r_skid_instr <= '0;
      r_skid_pc4   <= '0;
    end else begin
      r_pc  <= w_pc_d;
      r_tgt <= w_tgt_d;
      if (w_skid_we) begin
        r_skid_instr <= imem_rdata_i;
        r_skid_pc4   <= w_pc4;
      end
    end
  end

  pipe_reg_ifid #(
    .NOP_INSTR(NOP_INSTR)
  ) u_ifid (
    .CLK     (CLK),
    .RST     (RST),
    .i_load  (w_cap),
    .i_bubble(w_bubble),
    .i_instr (w_cap_instr),
    .i_pc4   (w_cap_pc4),
    .o_valid (ifid_valid_o),
    .o_instr (ifid_instr_o),
    .o_pc4   (ifid_pc4_o)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stall/flush/redirect/ack traffic, compared against a program-order model.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        stall_i = 1'b0, flush_i = 1'b0, redirect_i = 1'b0, imem_ack_i = 1'b0;
  logic [31:0] redirect_pc_i = '0, imem_rdata_i = '0;
  logic        imem_req_o, ifid_valid_o;
  logic [31:0] imem_addr_o, ifid_instr_o, ifid_pc4_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  fetch_stage #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .CLK(CLK), .RST(RST),
    .stall_i(stall_i), .flush_i(flush_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .ifid_valid_o(ifid_valid_o), .ifid_instr_o(ifid_instr_o), .ifid_pc4_o(ifid_pc4_o)
  );

  // Reference model: next fetch address, words waiting behind a stall,
  // and a pending "drop the next response, then jump" obligation.
  typedef struct { logic [31:0] instr; logic [31:0] pc4; } word_t;
  logic [31:0] m_pc, m_tgt;
  bit          m_drop;
  word_t       m_held[$];
  logic        m_valid;
  logic [31:0] m_instr, m_pc4;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC; m_tgt = '0; m_drop = 0; m_held.delete();
    m_valid = 1'b0; m_instr = NOP; m_pc4 = '0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".req"},   {31'd0, imem_req_o},   32'd0);
    check({tag, ".addr"},  imem_addr_o,           RPC);
    check({tag, ".valid"}, {31'd0, ifid_valid_o}, 32'd0);
    check({tag, ".instr"}, ifid_instr_o,          NOP);
    check({tag, ".pc4"},   ifid_pc4_o,            32'd0);
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".req"},   {31'd0, imem_req_o},   {31'd0, (m_held.size() == 0)});
    check({tag, ".addr"},  imem_addr_o,           m_pc);
    check({tag, ".valid"}, {31'd0, ifid_valid_o}, {31'd0, m_valid});
    check({tag, ".instr"}, ifid_instr_o,          m_instr);
    check({tag, ".pc4"},   ifid_pc4_o,            m_pc4);
  endtask

  task automatic model_edge();
    bit    cap;
    word_t w;
    cap = 0;
    w.instr = '0; w.pc4 = '0;
    if (redirect_i) begin
      if (m_held.size() != 0 || imem_ack_i) begin
        m_pc = redirect_pc_i & ~32'd3; m_drop = 0; m_held.delete();
      end else begin
        m_tgt = redirect_pc_i & ~32'd3; m_drop = 1;
      end
    end else if (m_held.size() != 0) begin
      if (!stall_i && !flush_i) begin w = m_held.pop_front(); cap = 1; end
    end else if (imem_ack_i) begin
      if (m_drop) begin
        m_pc = m_tgt; m_drop = 0;
      end else begin
        w.instr = imem_rdata_i; w.pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
        if (stall_i || flush_i) m_held.push_back(w);
        else cap = 1;
      end
    end
    if (cap) begin
      m_valid = 1'b1; m_instr = w.instr; m_pc4 = w.pc4;
    end else if (flush_i || redirect_i || !stall_i) begin
      m_valid = 1'b0; m_instr = NOP; m_pc4 = '0;
    end
  endtask

  // Drive one cycle: inputs set just after the edge, outputs compared at the
  // falling edge, model advanced on the rising edge.
  task automatic tick(input string tag, input bit st, input bit fl, input bit rd,
                      input logic [31:0] rpc, input bit ak);
    stall_i = st; flush_i = fl; redirect_i = rd; redirect_pc_i = rpc;
    imem_ack_i   = ak && (m_held.size() == 0);
    imem_rdata_i = imem_ack_i ? mem_word(m_pc) : 32'hDEAD_BEEF;
    @(negedge CLK);
    compare_model(tag);
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic do_reset(input string tag);
    stall_i = 0; flush_i = 0; redirect_i = 0; redirect_pc_i = '0;
    imem_ack_i = 0; imem_rdata_i = '0;
    RST = 1'b1;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_reset(tag);
    RST = 1'b0;
  endtask

  initial begin
    // Reset and zero-wait streaming
    do_reset("rst0");
    for (int i = 0; i < 4; i++) tick("stream", 0, 0, 0, '0, 1);
    check("stream.pc4_12", ifid_pc4_o, 32'h0000_0010);

    // Stall during zero-wait fetch at 0x10
    tick("stall_cap", 1, 0, 0, '0, 1);
    check("stall.hold_pc4", ifid_pc4_o, 32'h0000_0010);
    check("stall.req_low", {31'd0, imem_req_o}, 32'd0);
    tick("stall_hold", 1, 0, 0, '0, 1);
    tick("stall_hold", 1, 0, 0, '0, 1);
    tick("stall_rel", 0, 0, 0, '0, 1);
    check("stall.rel_pc4", ifid_pc4_o, 32'h0000_0014);
    tick("stall_next", 0, 0, 0, '0, 1);
    check("stall.next_pc4", ifid_pc4_o, 32'h0000_0018);

    // Delayed ack with redirect while waiting
    do_reset("rst1");
    tick("dly", 0, 0, 0, '0, 1);
    tick("dly", 0, 0, 0, '0, 1);
    tick("dly_redir", 0, 0, 1, 32'h0000_0200, 0);
    check("dly.addr_held", imem_addr_o, 32'h0000_0008);
    tick("dly_wait", 0, 0, 0, '0, 0);
    tick("dly_stale", 0, 0, 0, '0, 1);
    check("dly.new_addr", imem_addr_o, 32'h0000_0200);
    check("dly.no_stale", {31'd0, ifid_valid_o}, 32'd0);
    tick("dly_tgt", 0, 0, 0, '0, 1);
    check("dly.tgt_pc4", ifid_pc4_o, 32'h0000_0204);

    // Latest redirect wins in DISCARD
    tick("lw_r1", 0, 0, 1, 32'h0000_0040, 0);
    tick("lw_r2", 0, 0, 1, 32'h0000_0080, 0);
    tick("lw_ack", 0, 0, 0, '0, 1);
    check("lw.addr", imem_addr_o, 32'h0000_0080);

    // Redirect + stall + ack: bubble, jump, no buffering (low bits ignored)
    tick("rs_pre", 0, 0, 0, '0, 1);
    tick("rs", 1, 0, 1, 32'h0000_0302, 1);
    check("rs.req", {31'd0, imem_req_o}, 32'd1);
    check("rs.addr", imem_addr_o, 32'h0000_0300);
    check("rs.valid", {31'd0, ifid_valid_o}, 32'd0);

    // PC wrap, then asynchronous reset mid-request
    tick("wrap_redir", 0, 0, 1, 32'hFFFF_FFFC, 1);
    tick("wrap_fetch", 0, 0, 0, '0, 1);
    check("wrap.pc4", ifid_pc4_o, 32'h0000_0000);
    check("wrap.valid", {31'd0, ifid_valid_o}, 32'd1);
    check("wrap.addr", imem_addr_o, 32'h0000_0000);
    imem_ack_i = 0;
    #2;
    RST = 1'b1;
    #1;
    check_reset("async_rst");
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      bit st, fl, rd, ak;
      logic [31:0] rpc;
      st  = ($urandom_range(0, 99) < 25);
      fl  = ($urandom_range(0, 99) < 10);
      rd  = ($urandom_range(0, 99) < 8);
      ak  = ($urandom_range(0, 99) < 60);
      rpc = $urandom;
      tick("rand", st, fl, rd, rpc, ak);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
